// File: rtl/sonar_pkg.sv
// Shared types and default timing for the ultrasonic height sensor sequencer.
// Defaults are expressed in microseconds and converted to core clock cycles.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } sonar_state_t;

  localparam int unsigned CLK_HZ     = 48_000_000;
  localparam int unsigned TRIG_US    = 10;
  localparam int unsigned TIMEOUT_US = 38_000;
  localparam int unsigned PERIOD_US  = 60_000;

  function automatic int unsigned us_to_cycles(input int unsigned us);
    return us * (CLK_HZ / 1_000_000);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Brings the raw echo into the clk domain and flags its edges.
// Latency: echo_s lags echo by 2 cycles; rise/fall are valid in the first cycle echo_s changes.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic echo_s,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= echo;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign echo_s = sync_q;
  assign rise   = sync_q & ~dly_q;
  assign fall   = ~sync_q & dly_q;

endmodule

// File: rtl/sonar_ctrl.sv
// Ultrasonic measurement sequencer: trigger pulse, echo width timing, timeout and repetition period.
// Results are registered; valid/echo_width appear 3 cycles after the raw echo falls.
module sonar_ctrl
  import sonar_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = us_to_cycles(TRIG_US),
  parameter int unsigned TIMEOUT_CYCLES = us_to_cycles(TIMEOUT_US),
  parameter int unsigned PERIOD_CYCLES  = us_to_cycles(PERIOD_US)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [31:0] echo_width,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_W    = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);

  logic echo_s;
  logic rise;
  logic fall;

  echo_sync u_echo_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .echo   (echo),
    .echo_s (echo_s),
    .rise   (rise),
    .fall   (fall)
  );

  sonar_state_t state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  width_q, width_d;
  logic [31:0]  period_q, period_d;
  logic [31:0]  echo_width_q, echo_width_d;
  logic         trig_q, trig_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;
  logic         busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    width_d      = width_q;
    echo_width_d = echo_width_q;
    valid_d      = 1'b0;
    timeout_d    = 1'b0;
    // Period counter runs from trigger entry and saturates at its last value.
    period_d     = (period_q < PERIOD_LAST) ? period_q + 32'd1 : PERIOD_LAST;

    case (state_q)
      IDLE: begin
        period_d = '0;
        if (enable) begin
          state_d = TRIG;
          cnt_d   = '0;
          width_d = '0;
        end
      end

      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      WAIT_RISE: begin
        if (rise) begin
          state_d = MEASURE;
          width_d = 32'd1;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      MEASURE: begin
        if (fall) begin
          state_d      = HOLDOFF;
          echo_width_d = width_q;
          valid_d      = 1'b1;
        end else if (echo_s) begin
          // Echo still high on the cycle that would reach the limit: report a clipped width.
          if (width_q >= TIMEOUT_LAST) begin
            state_d      = HOLDOFF;
            echo_width_d = TIMEOUT_W;
            valid_d      = 1'b1;
            timeout_d    = 1'b1;
          end else begin
            width_d = width_q + 32'd1;
          end
        end
      end

      HOLDOFF: begin
        if ((period_q >= PERIOD_LAST) && !echo_s) begin
          if (enable) begin
            state_d  = TRIG;
            cnt_d    = '0;
            width_d  = '0;
            period_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    trig_d = (state_d == TRIG);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      width_q      <= '0;
      period_q     <= '0;
      echo_width_q <= '0;
      trig_q       <= 1'b0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      width_q      <= width_d;
      period_q     <= period_d;
      echo_width_q <= echo_width_d;
      trig_q       <= trig_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  assign trig       = trig_q;
  assign echo_width = echo_width_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sonar_ctrl.sv
// Directed bench for sonar_ctrl with TRIG=4, TIMEOUT=100, PERIOD=300 cycles.
module tb_sonar_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        echo;
  logic        trig;
  logic [31:0] echo_width;
  logic        valid;
  logic        timeout;
  logic        busy;

  always #5 clk = ~clk;

  sonar_ctrl #(
    .TRIG_CYCLES    (4),
    .TIMEOUT_CYCLES (100),
    .PERIOD_CYCLES  (300)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .echo       (echo),
    .trig       (trig),
    .echo_width (echo_width),
    .valid      (valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  int   trig_rise_cnt = 0;
  logic trig_prev = 1'b0;

  // Event counters sampled at the active edge, before the DUT's registers update.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (trig === 1'b1 && trig_prev === 1'b0) trig_rise_cnt <= trig_rise_cnt + 1;
    trig_prev <= trig;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return trig;
      1:       return valid;
      2:       return timeout;
      default: return busy;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input string tag, input int sel, input logic lvl, input int budget,
                          output int n);
    n = 0;
    while (pick(sel) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, 32'(pick(sel) === lvl), 32'd1);
  endtask

  function automatic logic [31:0] near50(input logic [31:0] w);
    return 32'((w >= 32'd49) && (w <= 32'd51));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, t1, t2, t3, vseen, to_seen, vc, tc;
    logic [31:0] w;

    rst_n  = 1'b0;
    enable = 1'b0;
    echo   = 1'b0;
    step(3);
    check("rst_trig",       32'(trig),    0);
    check("rst_echo_width", echo_width,   0);
    check("rst_valid",      32'(valid),   0);
    check("rst_timeout",    32'(timeout), 0);
    check("rst_busy",       32'(busy),    0);

    // Single measurement, 50-cycle echo starting 10 cycles after trig falls.
    rst_n  = 1'b1;
    enable = 1'b1;
    step(1);
    check("trig_after_enable", 32'(trig), 1);
    check("busy_after_enable", 32'(busy), 1);
    t0 = cyc;
    n = 0;
    while (trig === 1'b1 && n < 20) begin
      n++;
      step(1);
    end
    check("trig_high_cycles", n, 4);
    step(10);
    echo = 1'b1;
    step(50);
    echo = 1'b0;
    wait_for("valid1", 1, 1'b1, 10, n);
    check("valid_latency", n, 3);
    check("width1", near50(echo_width), 1);
    check("no_timeout1", 32'(timeout), 0);
    step(1);
    check("valid_one_cycle", 32'(valid), 0);

    // Second period, same echo.
    wait_for("trig2", 0, 1'b1, 400, n);
    t1 = cyc;
    check("period_1_2", t1 - t0, 300);
    wait_for("trig2_fall", 0, 1'b0, 10, n);
    step(10);
    echo = 1'b1;
    step(50);
    echo = 1'b0;
    wait_for("valid2", 1, 1'b1, 10, n);
    check("width2", near50(echo_width), 1);
    step(2);
    check("valid_cnt2", valid_cnt, 2);

    // Third period, no echo at all.
    wait_for("trig3", 0, 1'b1, 400, n);
    t2 = cyc;
    check("period_2_3", t2 - t1, 300);
    wait_for("trig3_fall", 0, 1'b0, 10, n);
    wait_for("timeout3", 2, 1'b1, 150, n);
    check("timeout_latency", n, 100);
    check("timeout_no_valid", 32'(valid), 0);
    check("width_kept", near50(echo_width), 1);
    step(1);
    check("timeout_one_cycle", 32'(timeout), 0);
    step(1);
    check("valid_cnt3", valid_cnt, 2);

    // Fourth period, echo stuck high for 500 cycles.
    wait_for("trig4", 0, 1'b1, 400, n);
    t3 = cyc;
    check("period_3_4", t3 - t2, 300);
    wait_for("trig4_fall", 0, 1'b0, 10, n);
    step(10);
    echo    = 1'b1;
    vseen   = 0;
    to_seen = 0;
    w       = '0;
    tc      = trig_rise_cnt;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (valid === 1'b1) begin
        vseen++;
        w       = echo_width;
        to_seen = int'(timeout);
      end
    end
    check("long_valid_count", vseen, 1);
    check("long_width", w, 100);
    check("long_timeout_with_valid", to_seen, 1);
    check("long_no_trig", trig_rise_cnt - tc, 0);
    echo = 1'b0;
    wait_for("trig5", 0, 1'b1, 10, n);
    check("trig_after_echo_low", n, 3);

    // Fifth period, enable dropped mid-measurement.
    wait_for("trig5_fall", 0, 1'b0, 10, n);
    step(10);
    echo = 1'b1;
    step(5);
    enable = 1'b0;
    step(45);
    echo = 1'b0;
    wait_for("valid5", 1, 1'b1, 10, n);
    check("width5", near50(echo_width), 1);
    wait_for("idle5", 3, 1'b0, 400, n);
    tc = trig_rise_cnt;
    step(400);
    check("no_trig_after_disable", trig_rise_cnt - tc, 0);
    check("idle_trig", 32'(trig), 0);
    check("idle_busy", 32'(busy), 0);

    // Reset during TRIG.
    vc     = valid_cnt;
    enable = 1'b1;
    step(1);
    check("trig_before_rst", 32'(trig), 1);
    rst_n = 1'b0;
    step(1);
    check("rstT_trig",       32'(trig),    0);
    check("rstT_busy",       32'(busy),    0);
    check("rstT_valid",      32'(valid),   0);
    check("rstT_timeout",    32'(timeout), 0);
    check("rstT_echo_width", echo_width,   0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("trig_after_rst", 32'(trig), 1);

    // Reset during MEASURE.
    wait_for("trig6_fall", 0, 1'b0, 10, n);
    echo = 1'b1;
    step(20);
    rst_n = 1'b0;
    step(1);
    check("rstM_trig",       32'(trig),    0);
    check("rstM_busy",       32'(busy),    0);
    check("rstM_valid",      32'(valid),   0);
    check("rstM_timeout",    32'(timeout), 0);
    check("rstM_echo_width", echo_width,   0);
    echo   = 1'b0;
    enable = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(50);
    check("rst_no_spurious_valid", valid_cnt - vc, 0);
    check("post_rst_echo_width", echo_width, 0);
    check("post_rst_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
